// File: rtl/alm_cluster_param.sv
// Parametrised adaptive logic cluster: NUM_LUT K-input LUTs grouped into
// fracturable pairs (wide LUT or ripple-carry full adder), loaded over a word port.

module alm_pair #(
    parameter int LUT_K = 4
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    input  logic                  i_clk_en,
    input  logic                  i_live,
    input  logic [2**LUT_K-1:0]   i_lut_a,
    input  logic [2**LUT_K-1:0]   i_lut_b,
    input  logic [LUT_K-1:0]      i_idx,
    input  logic                  i_sel,
    input  logic                  i_mode,
    input  logic                  i_regsel,
    input  logic                  i_ci,
    output logic                  o_co,
    output logic                  o_out
);
    logic w_a, w_b, w_f;
    logic r_q;

    assign w_a = i_lut_a[i_idx];
    assign w_b = i_lut_b[i_idx];

    always_comb begin
        w_f  = i_sel ? w_b : w_a;
        o_co = i_ci;
        if (i_mode) begin
            w_f  = w_a ^ w_b ^ i_ci;
            o_co = (w_a & w_b) | (w_a & i_ci) | (w_b & i_ci);
        end
    end

    // Register is held at zero until the cluster is fully configured.
    always_ff @(posedge i_clk) begin
        if (i_clr || !i_live)
            r_q <= 1'b0;
        else if (i_clk_en)
            r_q <= w_f;
    end

    assign o_out = i_regsel ? r_q : w_f;
endmodule

module alm_cluster_param #(
    parameter int LUT_K   = 4,
    parameter int NUM_LUT = 4,
    parameter int CFG_W   = 8
) (
    input  logic                        clk,
    input  logic                        clear_sync,
    input  logic                        clk_en,
    input  logic [NUM_LUT/2*LUT_K-1:0]  lut_in,
    input  logic [NUM_LUT/2-1:0]        lut_sel,
    input  logic                        carry_in,
    output logic                        carry_out,
    output logic [NUM_LUT/2-1:0]        out,
    input  logic                        cfg_start,
    input  logic [CFG_W-1:0]            cfg_data,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic                        cfg_done
);
    localparam int NUM_PAIR  = NUM_LUT / 2;
    localparam int LUT_N     = 2 ** LUT_K;
    localparam int MODE_BASE = NUM_LUT * LUT_N;
    localparam int RSEL_BASE = MODE_BASE + NUM_PAIR;
    localparam int CFG_BITS  = MODE_BASE + 2 * NUM_PAIR;
    localparam int CFG_WORDS = (CFG_BITS + CFG_W - 1) / CFG_W;
    localparam int CNT_W     = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CFG_BITS-1:0] r_cfg, w_cfg_nxt;
    logic                w_accept, w_last, w_live;
    logic [NUM_PAIR:0]   w_c;
    logic [NUM_PAIR-1:0] w_out;

    // A word offered in the same cycle as a restart is dropped.
    assign w_accept = (r_state == S_LOAD) && cfg_valid && !cfg_start;
    assign w_last   = (r_cnt == CNT_W'(CFG_WORDS - 1));
    assign w_live   = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cfg_start) w_next = S_LOAD;
            S_LOAD:  if (cfg_start) w_next = S_LOAD;
                     else if (w_accept && w_last) w_next = S_DONE;
            S_DONE:  if (cfg_start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear_sync)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Each config bit knows its own word slot; padding beyond CFG_BITS is never stored.
    genvar b;
    generate
        for (b = 0; b < CFG_BITS; b++) begin : g_bit
            assign w_cfg_nxt[b] = (w_accept && r_cnt == CNT_W'(b / CFG_W)) ?
                                  cfg_data[b % CFG_W] : r_cfg[b];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear_sync || cfg_start) begin
            r_cfg <= '0;
            r_cnt <= '0;
        end else begin
            r_cfg <= w_cfg_nxt;
            if (w_accept)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_c[0] = carry_in;

    genvar p;
    generate
        for (p = 0; p < NUM_PAIR; p++) begin : g_pair
            alm_pair #(.LUT_K(LUT_K)) u_pair (
                .i_clk    (clk),
                .i_clr    (clear_sync),
                .i_clk_en (clk_en),
                .i_live   (w_live),
                .i_lut_a  (r_cfg[(2*p)*LUT_N +: LUT_N]),
                .i_lut_b  (r_cfg[(2*p+1)*LUT_N +: LUT_N]),
                .i_idx    (lut_in[p*LUT_K +: LUT_K]),
                .i_sel    (lut_sel[p]),
                .i_mode   (r_cfg[MODE_BASE + p]),
                .i_regsel (r_cfg[RSEL_BASE + p]),
                .i_ci     (w_c[p]),
                .o_co     (w_c[p+1]),
                .o_out    (w_out[p])
            );
        end
    endgenerate

    assign out       = w_live ? w_out : '0;
    assign carry_out = w_live & w_c[NUM_PAIR];
    assign cfg_ready = (r_state == S_LOAD);
    assign cfg_done  = w_live;
endmodule
